mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 29 ++
 rtl/mem_responder_array.sv | 42 ++++
 rtl/mem_responder.sv | 226 ++++++++++++++++++++++
 tb/tb_mem_responder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// ----------------------------------------------------------------------------
// mem_responder_pkg
// Shared types and constants for the mem_responder slice:
//   state_e    - responder FSM states (IDLE, WAIT, RESP)
//   port_e     - which requester owns the access in flight (PORT_I, PORT_D)
//   WAIT_CNT_W - width of the wait-state down-counter (covers 0..15)
//   sat_inc    - 32-bit saturating increment, used by the optional
//                statistics counters (MEM_RESPONDER_STATS_EN)
// ----------------------------------------------------------------------------
package mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_e;

    localparam int WAIT_CNT_W = 4;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/mem_responder_array.sv
// ----------------------------------------------------------------------------
// mem_responder_array
// Word-addressed 32-bit storage, DEPTH_WORDS deep (power of two).
// Ports:
//   clk    - clock, rising edge
//   we     - write enable; wdata stored at waddr on the edge
//   waddr  - write word index
//   wdata  - write word
//   re     - read enable; rdata updated from raddr on the edge
//   raddr  - read word index
//   rdata  - registered read word (old contents on a same-edge write)
// ----------------------------------------------------------------------------
module mem_responder_array #(
    parameter  int DEPTH_WORDS = 256,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // NOTE: storage and its read register have no reset; contents must
    // survive reset, and a reset port would stop RAM inference.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// ----------------------------------------------------------------------------
// mem_responder
// Single-outstanding memory responder serving an instruction-fetch port and a
// data port from one word-addressed store, with WAIT_CYCLES wait states.
// A request sampled in IDLE cycle N is acked in cycle N+WAIT_CYCLES+1; the
// data port wins when both request together.
// Ports:
//   clk, reset           - clock and synchronous active-high reset
//   i_req/i_addr         - fetch request and byte address
//   i_rdata/i_ack        - fetched word and one-cycle completion pulse
//   d_req/d_wr/d_addr    - data request, write flag, byte address
//   d_wdata              - write word
//   d_rdata/d_ack        - read word and one-cycle completion pulse
//   err                  - marks the ack of the same cycle as failed
//                          (misaligned or out-of-range); no write, rdata=0
// Optional (macro MEM_RESPONDER_STATS_EN):
//   stat_ifetch, stat_dread, stat_dwrite, stat_err - saturating counts of
//   acked accesses; errored accesses count in stat_err only.
// ----------------------------------------------------------------------------
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        err
`ifdef MEM_RESPONDER_STATS_EN
    ,
    output logic [31:0] stat_ifetch,
    output logic [31:0] stat_dread,
    output logic [31:0] stat_dwrite,
    output logic [31:0] stat_err
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_e                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q,   cnt_d;
    port_e                   port_q,  port_d;
    logic                    wr_q,    wr_d;
    logic                    bad_q,   bad_d;
    logic [AW-1:0]           idx_q,   idx_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    i_ack_q, i_ack_d;
    logic                    d_ack_q, d_ack_d;
    logic                    err_q,   err_d;

    port_e                   sel_port;
    logic [31:0]             sel_addr;
    logic                    enter_resp;
    logic                    arr_we;
    logic [31:0]             arr_rdata;

    // Data port has priority over fetch when both request in IDLE.
    assign sel_port = d_req ? PORT_D : PORT_I;
    assign sel_addr = d_req ? d_addr : i_addr;

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        port_d     = port_q;
        wr_d       = wr_q;
        bad_d      = bad_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        i_ack_d    = 1'b0;
        d_ack_d    = 1'b0;
        err_d      = 1'b0;
        enter_resp = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (d_req || i_req) begin
                    port_d  = sel_port;
                    wr_d    = d_req & d_wr;
                    bad_d   = (sel_addr[1:0] != 2'b00) || (sel_addr[31:AW+2] != '0);
                    idx_d   = sel_addr[AW+1:2];
                    wdata_d = d_wdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_CNT_W'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                // The counter reaches zero on the edge that enters RESP, which
                // keeps WAIT exactly WAIT_CYCLES cycles long.
                cnt_d = cnt_q - WAIT_CNT_W'(1);
                if (cnt_q <= WAIT_CNT_W'(1)) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Ack/err are registered so they appear exactly in the RESP cycle.
        if (enter_resp) begin
            i_ack_d = (port_d == PORT_I);
            d_ack_d = (port_d == PORT_D);
            err_d   = bad_d;
        end
    end

    // Write commits on the edge entering RESP; a reset on that edge
    // abandons the access, so it must also block the write.
    assign arr_we = enter_resp && wr_d && !bad_d && !reset;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values computed above.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            port_q  <= PORT_I;
            wr_q    <= 1'b0;
            bad_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            i_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            port_q  <= port_d;
            wr_q    <= wr_d;
            bad_q   <= bad_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            i_ack_q <= i_ack_d;
            d_ack_q <= d_ack_d;
            err_q   <= err_d;
        end
    end

    // Read is launched on the same edge that enters RESP, so the
    // registered array output is valid during the ack cycle.
    mem_responder_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (idx_d),
        .wdata (wdata_d),
        .re    (enter_resp),
        .raddr (idx_d),
        .rdata (arr_rdata)
    );

    // rdata is forced to zero outside the ack cycle, on errors and on writes.
    assign i_ack   = i_ack_q;
    assign d_ack   = d_ack_q;
    assign err     = err_q;
    assign i_rdata = (i_ack_q && !bad_q)          ? arr_rdata : 32'd0;
    assign d_rdata = (d_ack_q && !bad_q && !wr_q) ? arr_rdata : 32'd0;

`ifdef MEM_RESPONDER_STATS_EN
    logic [31:0] st_if_q, st_if_d;
    logic [31:0] st_rd_q, st_rd_d;
    logic [31:0] st_wr_q, st_wr_d;
    logic [31:0] st_er_q, st_er_d;

    always_comb begin
        st_if_d = st_if_q;
        st_rd_d = st_rd_q;
        st_wr_d = st_wr_q;
        st_er_d = st_er_q;
        // Count once per ack, in the RESP cycle.
        if (state_q == RESP) begin
            if (err_q) begin
                st_er_d = sat_inc(st_er_q);
            end else if (i_ack_q) begin
                st_if_d = sat_inc(st_if_q);
            end else if (wr_q) begin
                st_wr_d = sat_inc(st_wr_q);
            end else begin
                st_rd_d = sat_inc(st_rd_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_if_q <= '0;
            st_rd_q <= '0;
            st_wr_q <= '0;
            st_er_q <= '0;
        end else begin
            st_if_q <= st_if_d;
            st_rd_q <= st_rd_d;
            st_wr_q <= st_wr_d;
            st_er_q <= st_er_d;
        end
    end

    assign stat_ifetch = st_if_q;
    assign stat_dread  = st_rd_q;
    assign stat_dwrite = st_wr_q;
    assign stat_err    = st_er_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_mem_responder
// Scoreboard bench for mem_responder (DEPTH_WORDS=256, WAIT_CYCLES=2).
// Drivers push the expected ack (data, err, ack cycle) into a per-port queue;
// a monitor on the falling edge pops and compares whenever an ack appears.
// Statistics outputs are connected and checked when MEM_RESPONDER_STATS_EN
// is defined.
// ----------------------------------------------------------------------------
module tb_mem_responder;

    localparam int W     = 2;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_wr;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [31:0] i_rdata, d_rdata;
    logic        i_ack, d_ack, err;
`ifdef MEM_RESPONDER_STATS_EN
    logic [31:0] stat_ifetch, stat_dread, stat_dwrite, stat_err;
`endif

    mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_ack   (i_ack),
        .d_req   (d_req),
        .d_wr    (d_wr),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_ack   (d_ack),
        .err     (err)
`ifdef MEM_RESPONDER_STATS_EN
        ,
        .stat_ifetch (stat_ifetch),
        .stat_dread  (stat_dread),
        .stat_dwrite (stat_dwrite),
        .stat_err    (stat_err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        wr;
        int          cycle;
    } exp_t;

    exp_t q_i[$];
    exp_t q_d[$];

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    // Reference counts of acked accesses since the last reset.
    int m_if = 0, m_rd = 0, m_wr = 0, m_er = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One access on one port; 'extra' is the number of cycles the ack is
    // expected to be delayed by another access served first.
    task automatic access(input bit is_d, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input bit exp_err, input int extra);
        exp_t e;
        bit   got;
        @(posedge clk); #1;
        if (is_d) begin
            d_req = 1'b1; d_wr = wr; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.wr    = is_d & wr;
        e.cycle = cyc + extra + W + 1;
        if (is_d) q_d.push_back(e); else q_i.push_back(e);
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            got = is_d ? d_ack : i_ack;
        end
        if (!got) check(is_d ? "d_ack_timeout" : "i_ack_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        if (is_d) d_req = 1'b0; else i_req = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        @(negedge clk);
        check({tag, "_i_ack"},   {31'd0, i_ack}, 32'd0);
        check({tag, "_d_ack"},   {31'd0, d_ack}, 32'd0);
        check({tag, "_err"},     {31'd0, err},   32'd0);
        check({tag, "_i_rdata"}, i_rdata,        32'd0);
        check({tag, "_d_rdata"}, d_rdata,        32'd0);
    endtask

    // Monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (i_ack) begin
                    if (q_i.size() == 0) begin
                        check("i_unexpected_ack", 32'd1, 32'd0);
                    end else begin
                        e = q_i.pop_front();
                        check("i_rdata",   i_rdata,      e.rdata);
                        check("i_err",     {31'd0, err}, {31'd0, e.err});
                        check("i_latency", 32'(cyc),     32'(e.cycle));
                        if (e.err) m_er++; else m_if++;
                    end
                end else begin
                    check("i_rdata_idle", i_rdata, 32'd0);
                end
                if (d_ack) begin
                    if (q_d.size() == 0) begin
                        check("d_unexpected_ack", 32'd1, 32'd0);
                    end else begin
                        e = q_d.pop_front();
                        if (!e.wr) check("d_rdata", d_rdata, e.rdata);
                        check("d_err",     {31'd0, err}, {31'd0, e.err});
                        check("d_latency", 32'(cyc),     32'(e.cycle));
                        if (e.err) m_er++; else if (e.wr) m_wr++; else m_rd++;
                    end
                end else begin
                    check("d_rdata_idle", d_rdata, 32'd0);
                end
                if (!i_ack && !d_ack) check("err_idle", {31'd0, err}, 32'd0);
                if (i_ack && d_ack)   check("dual_ack", 32'd1, 32'd0);
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_quiet("reset");
        mon_en = 1'b1;

        // Write then read back the same word
        access(1, 1, 32'h0000_0010, 32'hDEAD_BEEF, 32'd0,          0, 0);
        access(1, 0, 32'h0000_0010, 32'd0,         32'hDEAD_BEEF, 0, 0);

        // Simultaneous requests: data first, fetch after one IDLE cycle
        access(1, 1, 32'h0000_0000, 32'h1111_1111, 32'd0, 0, 0);
        access(1, 1, 32'h0000_0004, 32'h2222_2222, 32'd0, 0, 0);
        fork
            access(1, 0, 32'h0000_0000, 32'd0, 32'h1111_1111, 0, 0);
            access(0, 0, 32'h0000_0004, 32'd0, 32'h2222_2222, 0, W + 2);
        join

        // Misaligned write is rejected and leaves memory untouched
        access(1, 1, 32'h0000_0006, 32'hBAD0_BAD0, 32'd0,         1, 0);
        access(1, 0, 32'h0000_0004, 32'd0,         32'h2222_2222, 0, 0);

        // Reset in the last WAIT cycle of a write abandons it
        access(1, 1, 32'h0000_0020, 32'hA5A5_0020, 32'd0, 0, 0);
        @(posedge clk); #1;
        d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h0000_0020; d_wdata = 32'h1234_5678;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1; d_req = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        m_if = 0; m_rd = 0; m_wr = 0; m_er = 0;
        check_quiet("abandon");
        repeat (4) @(posedge clk);
        access(1, 0, 32'h0000_0020, 32'd0, 32'hA5A5_0020, 0, 0);

        // Address boundaries on the fetch port, storage retained over reset
        access(1, 1, 32'h0000_03FC, 32'hCAFE_F00D, 32'd0,         0, 0);
        access(0, 0, 32'h0000_03FC, 32'd0,         32'hCAFE_F00D, 0, 0);
        access(0, 0, 32'h0000_0400, 32'd0,         32'd0,         1, 0);
        access(0, 0, 32'h0000_0002, 32'd0,         32'd0,         1, 0);
        access(0, 0, 32'h0000_0010, 32'd0,         32'hDEAD_BEEF, 0, 0);
        access(1, 0, 32'hFFFF_FFF0, 32'd0,         32'd0,         1, 0);

        repeat (5) @(posedge clk);
        check("i_queue_empty", 32'(q_i.size()), 32'd0);
        check("d_queue_empty", 32'(q_d.size()), 32'd0);
`ifdef MEM_RESPONDER_STATS_EN
        check("stat_ifetch", stat_ifetch, 32'(m_if));
        check("stat_dread",  stat_dread,  32'(m_rd));
        check("stat_dwrite", stat_dwrite, 32'(m_wr));
        check("stat_err",    stat_err,    32'(m_er));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
